// File: rtl/ex_div_seq.sv
// ex_div_seq: multi-cycle RV64M divide sequencer for the EX stage.
// Radix-2 restoring shift-subtract divider, one quotient bit per cycle.
// Handles DIV/DIVU/REM/REMU and their W forms. Divide-by-zero and signed
// overflow resolve in one cycle without iterating.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a request; an accepted request stalls the pipe
// CALC  | iterating, one quotient bit per cycle, pipeline stalled
// DONE  | res_o holds the final result until res_ready_i
module ex_div_seq #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid_i,
  input  logic [2:0]      div_sel_i,
  input  logic [XLEN-1:0] src1_i,
  input  logic [XLEN-1:0] src2_i,
  input  logic            flush_i,
  input  logic            res_ready_i,
  output logic            div_ready_o,
  output logic            stall_o,
  output logic            res_valid_o,
  output logic [XLEN-1:0] res_o
);

  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_q;
  logic [CW-1:0]   cnt_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] b_abs_q;
  logic            q_neg_q;
  logic            r_neg_q;
  logic            rsel_q;
  logic            word_q;

  // Operand preparation signals (request side)
  logic            uns_in;
  logic            rsel_in;
  logic            word_in;
  logic [XLEN-1:0] a_p;
  logic [XLEN-1:0] b_p;
  logic            a_neg;
  logic            b_neg;
  logic [XLEN-1:0] a_abs;
  logic [XLEN-1:0] b_abs;
  logic [XLEN-1:0] quo_load;
  logic            b_zero;
  logic            a_min;
  logic            ovf;
  logic [XLEN-1:0] spec_res;

  // Iteration signals
  logic [XLEN:0]   rem_sh;
  logic            ge;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] quo_nxt;
  logic [XLEN-1:0] calc_res;

  // Sign-correct, select quotient/remainder and apply word extension.
  function automatic logic [XLEN-1:0] fin_res(
    input logic [XLEN-1:0] q,
    input logic [XLEN-1:0] r,
    input logic            qn,
    input logic            rn,
    input logic            rsel,
    input logic            word
  );
    logic [XLEN-1:0] v;
    if (rsel) v = rn ? (~r + 1'b1) : r;
    else      v = qn ? (~q + 1'b1) : q;
    return word ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  assign uns_in  = div_sel_i[0];
  assign rsel_in = div_sel_i[1];
  assign word_in = div_sel_i[2];

  // Width/sign preparation of the incoming operands and special-case detection
  always_comb begin
    a_p = src1_i;
    b_p = src2_i;
    if (word_in) begin
      a_p = {{(XLEN-32){src1_i[31] & ~uns_in}}, src1_i[31:0]};
      b_p = {{(XLEN-32){src2_i[31] & ~uns_in}}, src2_i[31:0]};
    end
    a_neg    = ~uns_in & a_p[XLEN-1];
    b_neg    = ~uns_in & b_p[XLEN-1];
    a_abs    = a_neg ? (~a_p + 1'b1) : a_p;
    b_abs    = b_neg ? (~b_p + 1'b1) : b_p;
    // Word ops park |a| in the upper half so 32 shifts leave the quotient low.
    quo_load = word_in ? {a_abs[31:0], {(XLEN-32){1'b0}}} : a_abs;
    b_zero   = (b_p == '0);
    a_min    = word_in ? (a_p == {{(XLEN-31){1'b1}}, 31'b0})
                       : (a_p == {1'b1, {(XLEN-1){1'b0}}});
    ovf      = ~uns_in & a_min & (b_p == '1);
    spec_res = b_zero ? fin_res('1, a_p, 1'b0, 1'b0, rsel_in, word_in)
                      : fin_res(a_p, '0, 1'b0, 1'b0, rsel_in, word_in);
  end

  // One restoring shift-subtract step and the result it would finalise
  always_comb begin
    rem_sh   = {rem_q, quo_q[XLEN-1]};
    // rem < |b| keeps rem_sh < 2|b|, so the low XLEN bits of diff are exact.
    ge       = rem_sh[XLEN] | (rem_sh[XLEN-1:0] >= b_abs_q);
    diff     = rem_sh[XLEN-1:0] - b_abs_q;
    rem_nxt  = ge ? diff : rem_sh[XLEN-1:0];
    quo_nxt  = {quo_q[XLEN-2:0], ge};
    calc_res = fin_res(quo_nxt, rem_nxt, q_neg_q, r_neg_q, rsel_q, word_q);
  end

  // Sequencer FSM with working registers and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      b_abs_q     <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      rsel_q      <= 1'b0;
      word_q      <= 1'b0;
      res_valid_o <= 1'b0;
      res_o       <= '0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      res_valid_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (div_valid_i) begin
            rsel_q  <= rsel_in;
            word_q  <= word_in;
            q_neg_q <= a_neg ^ b_neg;
            r_neg_q <= a_neg;
            if (b_zero || ovf) begin
              res_o       <= spec_res;
              res_valid_o <= 1'b1;
              state_q     <= DONE;
            end else begin
              rem_q   <= '0;
              quo_q   <= quo_load;
              b_abs_q <= b_abs;
              cnt_q   <= word_in ? CW'(32) : CW'(XLEN);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          rem_q <= rem_nxt;
          quo_q <= quo_nxt;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            res_o       <= calc_res;
            res_valid_o <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (res_ready_i) begin
            res_valid_o <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign div_ready_o = (state_q == IDLE);
  assign stall_o     = ~flush_i & ((state_q == CALC) ||
                                   ((state_q == IDLE) && div_valid_i));

endmodule

// File: tb/tb_ex_div_seq.sv
// Testbench for ex_div_seq: directed plan cases plus randomized ops checked
// against an arithmetic reference model of RV64M divide semantics.
module tb_ex_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        div_valid_i;
  logic [2:0]  div_sel_i;
  logic [63:0] src1_i;
  logic [63:0] src2_i;
  logic        flush_i;
  logic        res_ready_i;
  logic        div_ready_o;
  logic        stall_o;
  logic        res_valid_o;
  logic [63:0] res_o;

  int n_cmp = 0;
  int n_bad = 0;

  ex_div_seq #(.XLEN(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .div_valid_i (div_valid_i),
    .div_sel_i   (div_sel_i),
    .src1_i      (src1_i),
    .src2_i      (src2_i),
    .flush_i     (flush_i),
    .res_ready_i (res_ready_i),
    .div_ready_o (div_ready_o),
    .stall_o     (stall_o),
    .res_valid_o (res_valid_o),
    .res_o       (res_o)
  );

  always #5 clk = ~clk;

  // Reference: RISC-V M-extension divide results and expected latency.
  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic [2:0] sel, output int lat);
    logic [31:0] a32, b32, q32, r32, v32;
    logic [63:0] q64, r64;
    if (sel[2]) begin
      a32 = a[31:0];
      b32 = b[31:0];
      lat = 33;
      if (b32 == 32'd0) begin
        q32 = 32'hFFFF_FFFF; r32 = a32; lat = 1;
      end else if (!sel[0] && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin
        q32 = a32; r32 = 32'd0; lat = 1;
      end else if (sel[0]) begin
        q32 = a32 / b32; r32 = a32 % b32;
      end else begin
        q32 = $signed(a32) / $signed(b32); r32 = $signed(a32) % $signed(b32);
      end
      v32 = sel[1] ? r32 : q32;
      return {{32{v32[31]}}, v32};
    end
    lat = 65;
    if (b == 64'd0) begin
      q64 = '1; r64 = a; lat = 1;
    end else if (!sel[0] && a == 64'h8000_0000_0000_0000 && b == '1) begin
      q64 = a; r64 = 64'd0; lat = 1;
    end else if (sel[0]) begin
      q64 = a / b; r64 = a % b;
    end else begin
      q64 = $signed(a) / $signed(b); r64 = $signed(a) % $signed(b);
    end
    return sel[1] ? r64 : q64;
  endfunction

  // All tasks start and end just after a falling edge.
  task automatic issue(input logic [63:0] a, input logic [63:0] b, input logic [2:0] sel,
                       output logic st0, output logic rdy0);
    div_valid_i = 1'b1; src1_i = a; src2_i = b; div_sel_i = sel;
    #1;
    st0 = stall_o; rdy0 = div_ready_o;
    @(negedge clk);
    div_valid_i = 1'b0;
    src1_i = {$urandom, $urandom};
    src2_i = {$urandom, $urandom};
    div_sel_i = 3'($urandom);
  endtask

  task automatic wait_valid(output int lat, output int st_cnt);
    lat = 1; st_cnt = 0;
    while (res_valid_o !== 1'b1 && lat < 200) begin
      if (stall_o === 1'b1) st_cnt++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic retire();
    res_ready_i = 1'b1;
    @(negedge clk);
    res_ready_i = 1'b0;
  endtask

  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input logic [2:0] sel,
                       output logic [63:0] res, output int lat, output int st_cnt,
                       output logic st0, output logic st_done);
    logic rdy0;
    issue(a, b, sel, st0, rdy0);
    wait_valid(lat, st_cnt);
    res = res_o;
    st_done = stall_o;
    retire();
  endtask

  task automatic gen(output logic [63:0] a, output logic [63:0] b, output logic [2:0] sel);
    int m;
    sel = 3'($urandom);
    m = $urandom_range(0, 5);
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    case (m)
      0: b = sel[2] ? {b[63:32], 32'h0} : 64'h0;
      1: begin
        a = sel[2] ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = sel[2] ? {b[63:32], 32'hFFFF_FFFF} : '1;
      end
      2: begin
        a = 64'($urandom_range(0, 1000));
        b = 64'($urandom_range(1, 50));
        if ($urandom_range(0, 1) == 1) a = -a;
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      3: begin
        b = 64'($urandom_range(1, 15));
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      default: ;
    endcase
  endtask

  task automatic test_reset();
    rst = 1'b1; div_valid_i = 1'b0; flush_i = 1'b0; res_ready_i = 1'b0;
    div_sel_i = 3'd0; src1_i = 64'd0; src2_i = 64'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (div_ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b expected 1", div_ready_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b expected 0", stall_o); end
    n_cmp++; if (res_valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", res_valid_o); end
    n_cmp++; if (res_o !== 64'd0) begin n_bad++; $display("FAIL reset_res: got %h expected 0", res_o); end
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [63:0] ca [6] = '{64'hFFFF_FFFF_FFFF_FFF9, 64'hDEAD_BEEF_FFFF_FFF9, 64'd123,
                            64'd123, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    logic [63:0] cb [6] = '{64'd2, 64'h1234_5678_0000_0002, 64'd0, 64'd0, '1, '1};
    logic [2:0]  cs [6] = '{3'b000, 3'b110, 3'b001, 3'b011, 3'b000, 3'b010};
    logic [63:0] cr [6] = '{64'hFFFF_FFFF_FFFF_FFFD, '1, '1, 64'd123,
                            64'h8000_0000_0000_0000, 64'd0};
    int          cl [6] = '{65, 33, 1, 1, 1, 1};
    logic [63:0] r;
    int lat, stc;
    logic st0, std;
    for (int i = 0; i < 6; i++) begin
      do_op(ca[i], cb[i], cs[i], r, lat, stc, st0, std);
      n_cmp++; if (r !== cr[i]) begin n_bad++; $display("FAIL dir_res[%0d]: got %h expected %h", i, r, cr[i]); end
      n_cmp++; if (lat != cl[i]) begin n_bad++; $display("FAIL dir_lat[%0d]: got %0d expected %0d", i, lat, cl[i]); end
      n_cmp++; if (stc != cl[i] - 1) begin n_bad++; $display("FAIL dir_stall_cnt[%0d]: got %0d expected %0d", i, stc, cl[i] - 1); end
      n_cmp++; if (st0 !== 1'b1) begin n_bad++; $display("FAIL dir_stall_accept[%0d]: got %b expected 1", i, st0); end
      n_cmp++; if (std !== 1'b0) begin n_bad++; $display("FAIL dir_stall_done[%0d]: got %b expected 0", i, std); end
    end
  endtask

  task automatic test_flush();
    logic st0, rdy0, std;
    logic [63:0] r;
    int lat, stc;
    bit seen;
    issue(64'h0123_4567_89AB_CDEF, 64'd3, 3'b000, st0, rdy0);
    repeat (19) @(negedge clk);
    flush_i = 1'b1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL flush_stall: got %b expected 0", stall_o); end
    @(negedge clk);
    flush_i = 1'b0;
    #1;
    n_cmp++; if (div_ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_idle: got %b expected 1", div_ready_o); end
    seen = 1'b0;
    repeat (80) begin
      if (res_valid_o !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL flush_no_valid: got valid seen expected none"); end
    do_op(64'd100, 64'd7, 3'b001, r, lat, stc, st0, std);
    n_cmp++; if (r !== 64'd14) begin n_bad++; $display("FAIL flush_divu: got %h expected 14", r); end
    n_cmp++; if (lat != 65) begin n_bad++; $display("FAIL flush_divu_lat: got %0d expected 65", lat); end
    do_op(64'd100, 64'd7, 3'b011, r, lat, stc, st0, std);
    n_cmp++; if (r !== 64'd2) begin n_bad++; $display("FAIL flush_remu: got %h expected 2", r); end
  endtask

  task automatic test_hold();
    logic st0, rdy0;
    logic [63:0] r0, exp;
    int lat, stc, elat;
    exp = model(64'hFFFF_FFF0_1234_5678, 64'h0000_0000_0000_1357, 3'b000, elat);
    issue(64'hFFFF_FFF0_1234_5678, 64'h0000_0000_0000_1357, 3'b000, st0, rdy0);
    wait_valid(lat, stc);
    r0 = res_o;
    n_cmp++; if (r0 !== exp) begin n_bad++; $display("FAIL hold_res: got %h expected %h", r0, exp); end
    n_cmp++; if (div_ready_o !== 1'b0) begin n_bad++; $display("FAIL hold_not_ready: got %b expected 0", div_ready_o); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++; if (res_valid_o !== 1'b1 || res_o !== exp) begin
        n_bad++; $display("FAIL hold_stable[%0d]: got valid=%b res=%h expected valid=1 res=%h", i, res_valid_o, res_o, exp);
      end
    end
    retire();
    #1;
    n_cmp++; if (div_ready_o !== 1'b1 || res_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL hold_release: got ready=%b valid=%b expected ready=1 valid=0", div_ready_o, res_valid_o);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic st0, rdy0;
    bit seen;
    issue(64'h7777_0000_1111_2222, 64'd5, 3'b001, st0, rdy0);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (div_ready_o !== 1'b1 || stall_o !== 1'b0 || res_valid_o !== 1'b0 || res_o !== 64'd0) begin
      n_bad++; $display("FAIL mid_reset: got ready=%b stall=%b valid=%b res=%h expected 1 0 0 0", div_ready_o, stall_o, res_valid_o, res_o);
    end
    seen = 1'b0;
    repeat (70) begin
      if (res_valid_o !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++; if (seen) begin n_bad++; $display("FAIL mid_reset_no_valid: got valid seen expected none"); end
  endtask

  task automatic test_back_to_back();
    logic st0, rdy0;
    logic [63:0] ea, eb;
    logic [63:0] aa = 64'h0FED_CBA9_8765_4321, ab = 64'hFFFF_FFFF_FFFF_FF83;
    logic [63:0] ba = 64'hAAAA_5555_F000_0001, bb = 64'h1234_0000_0000_0019;
    int lat, stc, el;
    ea = model(aa, ab, 3'b000, el);
    eb = model(ba, bb, 3'b110, el);
    issue(aa, ab, 3'b000, st0, rdy0);
    wait_valid(lat, stc);
    n_cmp++; if (res_o !== ea) begin n_bad++; $display("FAIL b2b_res_a: got %h expected %h", res_o, ea); end
    res_ready_i = 1'b1;
    div_valid_i = 1'b1; src1_i = ba; src2_i = bb; div_sel_i = 3'b110;
    #1;
    n_cmp++; if (stall_o !== 1'b0 || div_ready_o !== 1'b0) begin
      n_bad++; $display("FAIL b2b_done_cycle: got stall=%b ready=%b expected 0 0", stall_o, div_ready_o);
    end
    @(negedge clk);
    res_ready_i = 1'b0;
    #1;
    n_cmp++; if (div_ready_o !== 1'b1 || stall_o !== 1'b1 || res_valid_o !== 1'b0) begin
      n_bad++; $display("FAIL b2b_accept: got ready=%b stall=%b valid=%b expected 1 1 0", div_ready_o, stall_o, res_valid_o);
    end
    @(negedge clk);
    div_valid_i = 1'b0; src1_i = {$urandom, $urandom}; src2_i = {$urandom, $urandom};
    wait_valid(lat, stc);
    n_cmp++; if (res_o !== eb) begin n_bad++; $display("FAIL b2b_res_b: got %h expected %h", res_o, eb); end
    n_cmp++; if (lat != 33) begin n_bad++; $display("FAIL b2b_lat_b: got %0d expected 33", lat); end
    retire();
  endtask

  task automatic test_random();
    logic [63:0] a, b, r, exp;
    logic [2:0]  sel;
    logic        st0, std;
    int lat, stc, elat;
    for (int i = 0; i < 60; i++) begin
      gen(a, b, sel);
      exp = model(a, b, sel, elat);
      do_op(a, b, sel, r, lat, stc, st0, std);
      n_cmp++; if (r !== exp) begin
        n_bad++; $display("FAIL rnd_res[%0d]: a=%h b=%h sel=%b got %h expected %h", i, a, b, sel, r, exp);
      end
      n_cmp++; if (lat != elat) begin
        n_bad++; $display("FAIL rnd_lat[%0d]: sel=%b got %0d expected %0d", i, sel, lat, elat);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ex_div_seq.md
Name: ex_div_seq

Overview:
- Sequencer for the multi-cycle RV64M divide path in the EX stage.
- Accepts one DIV/DIVU/REM/REMU(W) request from EX and runs a radix-2 restoring shift-subtract iteration, one quotient bit per cycle.
- Holds the pipeline stall while the operation is busy and presents the sign-corrected, width-corrected result until the pipeline consumes it.
- Replaces the tied-off DivEn/DivSel path of the ALU.

Parameters:
- XLEN, 64, datapath width; the W variants operate on the low 32 bits.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous active-high reset
- div_valid_i  input  1  EX holds a divide instruction
- div_sel_i  input  3  [0]=unsigned, [1]=remainder (else quotient), [2]=word op
- src1_i  input  XLEN  dividend
- src2_i  input  XLEN  divisor
- flush_i  input  1  pipeline flush; kills any operation in flight
- res_ready_i  input  1  pipeline advances out of EX this cycle
- div_ready_o  output  1  idle; a request is accepted this cycle
- stall_o  output  1  freeze IF/ID/EX while the divide is unresolved
- res_valid_o  output  1  res_o holds a final result
- res_o  output  XLEN  quotient or remainder

Behaviour:
- Reset: state=IDLE; div_ready_o=1; stall_o=0; res_valid_o=0; res_o=0; counter and working registers are zero.
- Operand prep on accept:
  - Word signed: sign-extend bit 31. Word unsigned: zero-extend bit 31.
  - Signed ops: take absolute values. Record q_neg = sign(a) XOR sign(b) and r_neg = sign(a).
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - Accept when div_valid_i && !flush_i.
  - Divisor == 0 (after width prep): go to DONE. Quotient = all ones; remainder = prepared dividend.
  - Signed overflow (dividend = most-negative value for the width, divisor = -1): go to DONE. Quotient = dividend; remainder = 0.
  - Otherwise: load remainder = 0, quotient register = |a|, cnt = 64 (or 32 for word ops); go to CALC.
- CALC, per cycle:
  - {rem,quo} shifts left by 1; trial = rem_shifted - |b|.
  - If trial is non-negative: rem = trial and the new quotient LSB = 1; otherwise the LSB = 0.
  - cnt decrements by 1. On cnt==1: go to DONE and register the final result.
- Final result:
  - Negate the quotient if q_neg and the remainder if r_neg (signed ops only).
  - Select per div_sel_i[1].
  - Word ops: sign-extend bit 31 of the 32-bit result to XLEN, for both signed and unsigned variants.
- DONE: res_valid_o=1 and res_o is stable. When res_ready_i=1, go to IDLE next cycle and drop res_valid_o.
- Latency:
  - res_valid_o rises N+1 cycles after the accept edge, where N = 64 (double) or 32 (word).
  - Special cases: res_valid_o rises 1 cycle after accept.
- stall_o = (state==CALC) || (state==IDLE && div_valid_i && !flush_i). Deasserted in DONE so EX can advance.
- div_ready_o = (state==IDLE).
- Inputs in CALC/DONE: div_sel_i, src1_i and src2_i are ignored after accept. Only latched copies are used.
- Flush: flush_i in any state forces IDLE next cycle, res_valid_o=0 and stall_o=0 that cycle. Flush has priority over res_ready_i and over a new request.
- Reset mid-operation: same as the reset state; no partial result is exposed.
- Back-to-back: a new request is accepted only after the cycle spent returning to IDLE. The minimum issue interval is N+2 cycles.

Test Plan:
- DIV signed double: 64'hFFFF_FFFF_FFFF_FFF9 (-7) / 2 -> res_o = -3 (64'hFFFF_FFFF_FFFF_FFFD). res_valid_o rises on cycle 65 after accept; stall_o high cycles 0..64.
- REMW: src1=32'hFFFF_FFF9 (upper bits garbage), src2=2 -> res_o = 64'hFFFF_FFFF_FFFF_FFFF (-1); valid on cycle 33.
- DIVU by zero: src1=123, src2=0 -> res_o = 64'hFFFF_FFFF_FFFF_FFFF after 1 cycle. Same operands with REMU -> 123.
- DIV overflow: 64'h8000_0000_0000_0000 / -1 -> quotient 64'h8000_0000_0000_0000 after 1 cycle; REM of the same operands -> 0.
- Flush at cycle 20 of a CALC -> IDLE next cycle, res_valid_o never asserts. A fresh DIVU 100/7 then gives 14; REMU gives 2.
- Hold: leave res_ready_i low for 5 cycles in DONE -> res_o is stable and res_valid_o stays high. With res_ready_i=1, IDLE follows next cycle and div_ready_o=1.
